timing_sequencer: RTL
=====================

# timing_sequencer

Multi-cycle control timing generator for the RISC CPU. A 3-bit sequence counter and a RUN/HALT state machine produce one-hot timing signals T0..T7 and a latched one-hot opcode decode D0..D7. The control-logic equations consume these signals to sequence fetch, decode and execute steps. Instruction boundaries are marked by `sc_clr`; halt requests are honoured only at a boundary.

## Interface
- `MAX_T`, default 7: last legal timing step. Range 3..7. Reaching it without `sc_clr` wraps the counter and flags an error.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `start` in 1: leave IDLE/HALT and begin at T0.
- `hlt` in 1: request halt at the next instruction boundary.
- `sc_clr` in 1: end of instruction; counter returns to 0.
- `stall` in 1: hold the counter (memory wait).
- `ir_op` in 3: opcode field of the instruction register.
- `t` out 8: one-hot timing; `t[k]`=1 iff RUN and `sc`==k.
- `d` out 8: one-hot latched opcode decode.
- `sc` out 3: current sequence count.
- `running` out 1: state is RUN.
- `halted` out 1: state is HALT.
- `wrap_err` out 1: sticky; counter wrapped without `sc_clr`.

## Operation
- States are IDLE, RUN and HALT. Reset enters IDLE.
- **IDLE/HALT:**
  - `sc` is held at 0 and `t` = 0.
  - `start`=1 moves to RUN at the next edge with `sc`=0, clears `wrap_err` and the pending-halt flag.
- **RUN, counter update priority (highest first):**
  1. `rst_n`=0
  2. `sc_clr`
  3. `stall`
  4. increment
- **Boundary conditions in RUN:**
  - Increment at `sc`==`MAX_T` sets `sc` to 0 and sets `wrap_err`.
  - `sc_clr` together with `stall`: clear wins.
- **Halt:**
  - `hlt`=1 in RUN sets an internal pending flag, even if it is pulsed for a single cycle.
  - On the next edge where `sc_clr`=1 and the flag is set, the block enters HALT (`sc`=0) and the flag clears.
  - `hlt` and `sc_clr` asserted in the same cycle halt immediately at that edge.
- **Opcode latch:**
  - On an edge where RUN, `sc`==2 and `stall`=0, `d` is loaded with the one-hot of `ir_op`.
  - `d` holds otherwise, including through HALT. It is cleared only by reset.
- `start` while already RUN is ignored.
- `hlt` outside RUN is ignored.
- **Reset values:** IDLE, `sc`=0, `t`=0, `d`=0, `running`=0, `halted`=0, `wrap_err`=0, pending flag 0.

## Timing
- All state registers update on the rising edge of `clk`.
- `t`, `running` and `halted` are combinational from registered state: no extra latency, glitch-free relative to `clk`.
- Latencies:
  - `start` sampled at edge n: `t`=8'h01 from edge n to n+1.
  - Each unstalled cycle advances `t` one position.
  - `sc_clr` at edge m: `t`=8'h01 after m.
  - `d` is valid from the edge that ends T2 until the next T2 edge.
- Reset mid-instruction takes effect at the next edge regardless of `stall`/`sc_clr`.

## Structure
- Shared package (`cpu_ctrl_pkg`) holds:
  - state enum `seq_state_t` (IDLE, RUN, HALT)
  - width constant `SC_W`=3
  - named step indices `T_FETCH0`=0, `T_FETCH1`=1, `T_DECODE`=2
- Sub-module `onehot_dec3x8`:
  - 3-bit in, 8-bit one-hot out, combinational.
  - Instantiated twice: once for `t` (output gated by `running`), once feeding the `d` register.

## Test plan
- **Reset and start:** reset, `start` pulse, no stall/clr → `t` steps 01,02,04,08,10,20,40,80, then 01 with `wrap_err`=1 (`MAX_T`=7).
- **Opcode latch:** `ir_op`=3'b101 during T2, changed to 3'b010 at T3 → `d`=8'h20, held through T3..T7.
- **Stall:** `stall`=1 for 3 cycles at `sc`=1 → `t` stays 8'h02 for 4 cycles. Same test with `sc_clr`=1 during the stall → `sc`=0 next cycle.
- **Halt at boundary:** one-cycle `hlt` pulse at T1, `sc_clr` at T4 → `running` stays 1 through T4. After that edge `halted`=1, `t`=0, `sc`=0, `d` is preserved.
- **Restart from HALT:** `start` with `wrap_err` previously set → RUN, `t`=8'h01, `wrap_err`=0. `start` during RUN has no effect on `sc`.
- **Reset mid-instruction:** `rst_n`=0 at `sc`=5 while `stall`=1 → next cycle IDLE with all outputs 0. `MAX_T`=4 variant: wrap after T4.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared control-path types and constants for the CPU timing logic.
// Imported by the sequencer and its decoders.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT
  } seq_state_t;

  localparam int SC_W = 3;

  localparam logic [SC_W-1:0] T_FETCH0 = 3'd0;
  localparam logic [SC_W-1:0] T_FETCH1 = 3'd1;
  localparam logic [SC_W-1:0] T_DECODE = 3'd2;

endpackage

// File: rtl/onehot_dec3x8.sv
// 3-to-8 one-hot decoder, purely combinational.
// Used for the timing strobes and the opcode decode.
module onehot_dec3x8 (
  input  logic [2:0] in_i,
  output logic [7:0] out_o
);

  assign out_o = 8'b0000_0001 << in_i;

endmodule

// File: rtl/timing_sequencer.sv
// Sequence counter with RUN/HALT control producing T0..T7 strobes
// and the latched opcode decode D0..D7.
module timing_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int MAX_T = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            hlt,
  input  logic            sc_clr,
  input  logic            stall,
  input  logic [2:0]      ir_op,
  output logic [7:0]      t,
  output logic [7:0]      d,
  output logic [SC_W-1:0] sc,
  output logic            running,
  output logic            halted,
  output logic            wrap_err
);

  localparam logic [SC_W-1:0] SC_MAX = SC_W'(MAX_T);

  seq_state_t      state_q, state_d;
  logic [SC_W-1:0] sc_q, sc_d;
  logic [7:0]      d_q, d_d;
  logic            wrap_q, wrap_d;
  logic            pend_q, pend_d;
  logic [7:0]      t_dec;
  logic [7:0]      op_dec;

  onehot_dec3x8 u_t_dec (
    .in_i  (sc_q),
    .out_o (t_dec)
  );

  onehot_dec3x8 u_op_dec (
    .in_i  (ir_op),
    .out_o (op_dec)
  );

  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    d_d     = d_q;
    wrap_d  = wrap_q;
    pend_d  = pend_q;
    case (state_q)
      S_RUN: begin
        if (sc_q == T_DECODE && !stall) begin
          d_d = op_dec;
        end
        pend_d = pend_q | hlt;
        if (sc_clr) begin
          sc_d = T_FETCH0;
          // a halt request in the same cycle as the boundary counts
          if (pend_q | hlt) begin
            state_d = S_HALT;
            pend_d  = 1'b0;
          end
        end else if (!stall) begin
          if (sc_q == SC_MAX) begin
            sc_d   = T_FETCH0;
            wrap_d = 1'b1;
          end else begin
            sc_d = sc_q + 1'b1;
          end
        end
      end
      default: begin
        sc_d = T_FETCH0;
        if (start) begin
          state_d = S_RUN;
          wrap_d  = 1'b0;
          pend_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sc_q    <= '0;
      d_q     <= '0;
      wrap_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      d_q     <= d_d;
      wrap_q  <= wrap_d;
      pend_q  <= pend_d;
    end
  end

  assign running  = (state_q == S_RUN);
  assign halted   = (state_q == S_HALT);
  assign t        = t_dec & {8{running}};
  assign d        = d_q;
  assign sc       = sc_q;
  assign wrap_err = wrap_q;

endmodule
